// File: rtl/spell_mem_initiator.sv
// spell_mem_initiator: bus master issuing single accesses to the spell memory responder
module spell_mem_initiator #(
  parameter int MIN_WAIT = 5,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_type,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic       resp_error,
  output logic [7:0] resp_rdata,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [1:0] mem_type,
  output logic       mem_write,
  input  logic [7:0] mem_rdata,
  input  logic       mem_data_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic req_ready_q, req_ready_d;
  logic resp_valid_q, resp_valid_d;
  logic resp_error_q, resp_error_d;
  logic [7:0] resp_rdata_q, resp_rdata_d;
  logic mem_select_q, mem_select_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic [1:0] mem_type_q, mem_type_d;
  logic mem_write_q, mem_write_d;
  logic ready_ok, timed_out;
  assign ready_ok  = mem_data_ready && (wcnt_q >= CNT_W'(MIN_WAIT));
  assign timed_out = wcnt_q == CNT_W'(TIMEOUT);
  // next state: accept in IDLE, wait for masked ready or timeout in ACCESS, one gap cycle in RECOVER
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_error_d = resp_error_q;
    resp_rdata_d = resp_rdata_q;
    mem_select_d = mem_select_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_type_d   = mem_type_q;
    mem_write_d  = mem_write_q;
    case (state_q)
      IDLE: begin
        req_ready_d  = 1'b1;
        mem_select_d = 1'b0;
        if (req_valid) begin
          mem_addr_d   = req_addr;
          mem_wdata_d  = req_wdata;
          mem_type_d   = req_type;
          mem_write_d  = req_write;
          mem_select_d = 1'b1;
          wcnt_d       = '0;
          req_ready_d  = 1'b0;
          resp_error_d = 1'b0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (ready_ok || timed_out) begin
          resp_valid_d = 1'b1;
          resp_error_d = !ready_ok;
          resp_rdata_d = (ready_ok && !mem_write_q) ? mem_rdata : 8'h00;
          mem_select_d = 1'b0;
          mem_write_d  = 1'b0;
          state_d      = RECOVER;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      RECOVER: begin
        mem_select_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_select_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_type_q   <= '0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_select_q <= mem_select_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_type_q   <= mem_type_d;
      mem_write_q  <= mem_write_d;
    end
  end
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_select = mem_select_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_type   = mem_type_q;
  assign mem_write  = mem_write_q;
endmodule

// File: tb/tb_spell_mem_initiator.sv
// tb_spell_mem_initiator: scoreboard bench with a behavioural responder
module tb_spell_mem_initiator;
  localparam int LAT = 5;
  logic clock = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_write;
  logic [1:0] req_type;
  logic [7:0] req_addr, req_wdata;
  logic resp_valid, resp_error;
  logic [7:0] resp_rdata;
  logic mem_select, mem_write, mem_data_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] mem_type;
  int checks = 0;
  int failures = 0;
  typedef struct packed {logic err; logic [7:0] data;} exp_t;
  exp_t sb[$];
  logic [7:0] ref_mem [256];
  logic [7:0] resp_mem [256];
  int mode = 0;
  logic sel_prev = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic rdy = 1'b0;
  logic [7:0] rd_q = 8'h00;
  int low_run = 100;
  int min_gap = 99;

  always #5 clock = ~clock;

  spell_mem_initiator dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_data_ready(mem_data_ready)
  );

  // responder: mode 0 ready LAT edges after select rise (sticky), mode 1 always ready, mode 2 never
  assign mem_data_ready = (mode == 1) ? 1'b1 : rdy;
  assign mem_rdata = (mode == 1) ? resp_mem[mem_addr] : rd_q;
  always @(posedge clock) begin
    sel_prev <= mem_select;
    if (mem_select && !sel_prev) begin
      cnt <= 4'd1;
      rdy <= 1'b0;
    end else if (mem_select && cnt != 4'd0) begin
      cnt <= (cnt == 4'(LAT - 1)) ? 4'd0 : cnt + 4'd1;
      if (cnt == 4'(LAT - 1) && mode == 0) begin
        rdy <= 1'b1;
        if (mem_write) resp_mem[mem_addr] <= mem_wdata;
        else rd_q <= resp_mem[mem_addr];
      end
    end
  end

  // shortest run of select-low samples preceding a select rise
  always @(negedge clock) begin
    if (mem_select) begin
      if (low_run > 0 && low_run < min_gap) min_gap <= low_run;
      low_run <= 0;
    end else low_run <= low_run + 1;
  end

  task automatic issue(input logic w, input logic [1:0] t, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_ready got=%b want=1", req_ready);
    end
    req_valid = 1'b1;
    req_write = w;
    req_type = t;
    req_addr = a;
    req_wdata = d;
    @(posedge clock);
    sb.push_back(exp_t'({1'b0, w ? 8'h00 : ref_mem[a]}));
    if (w) ref_mem[a] = d;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n, output bit got);
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    got = resp_valid;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if ({resp_error, resp_rdata} !== 9'h0) begin failures++; $display("FAIL reset_resp got=%h want=0", {resp_error, resp_rdata}); end
    checks++; if (mem_select !== 1'b0) begin failures++; $display("FAIL reset_mem_select got=%b want=0", mem_select); end
    checks++; if ({mem_addr, mem_wdata, mem_type, mem_write} !== 19'h0) begin failures++; $display("FAIL reset_mem_bus got=%h want=0", {mem_addr, mem_wdata, mem_type, mem_write}); end
  endtask

  task automatic test_read();
    int n;
    bit got;
    exp_t e;
    resp_mem[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    issue(1'b0, 2'd1, 8'h10, 8'h00);
    checks++; if ({mem_select, mem_type, mem_addr, mem_write} !== {1'b1, 2'd1, 8'h10, 1'b0}) begin failures++; $display("FAIL read_bus got=%h want=%h", {mem_select, mem_type, mem_addr, mem_write}, {1'b1, 2'd1, 8'h10, 1'b0}); end
    wait_resp(n, got);
    checks++;
    if (!got) begin failures++; $display("FAIL read_resp_timeout got=none want=resp"); end
    else begin
      e = sb.pop_front();
      if ({resp_error, resp_rdata} !== e) begin failures++; $display("FAIL read_data got=%h want=%h", {resp_error, resp_rdata}, e); end
    end
    checks++; if (n != 7) begin failures++; $display("FAIL read_latency got=%0d want=7", n); end
    @(negedge clock);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL read_pulse got=%b want=0", resp_valid); end
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL read_ready_after got=%b want=1", req_ready); end
  endtask

  task automatic test_write_read();
    int n;
    bit got;
    exp_t e;
    min_gap = 99;
    issue(1'b1, 2'd0, 8'h80, 8'h3C);
    checks++; if ({mem_write, mem_wdata, mem_addr} !== {1'b1, 8'h3C, 8'h80}) begin failures++; $display("FAIL write_bus got=%h want=%h", {mem_write, mem_wdata, mem_addr}, {1'b1, 8'h3C, 8'h80}); end
    wait_resp(n, got);
    checks++;
    if (!got) begin failures++; $display("FAIL write_resp_timeout got=none want=resp"); end
    else begin
      e = sb.pop_front();
      if ({resp_error, resp_rdata} !== e) begin failures++; $display("FAIL write_data got=%h want=%h", {resp_error, resp_rdata}, e); end
    end
    issue(1'b0, 2'd0, 8'h80, 8'h00);
    wait_resp(n, got);
    checks++;
    if (!got) begin failures++; $display("FAIL wr_read_resp_timeout got=none want=resp"); end
    else begin
      e = sb.pop_front();
      if ({resp_error, resp_rdata} !== {1'b0, 8'h3C}) begin failures++; $display("FAIL wr_read_data got=%h want=%h", {resp_error, resp_rdata}, e); end
    end
    checks++; if (min_gap < 2) begin failures++; $display("FAIL wr_select_gap got=%0d want>=2", min_gap); end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_stale_ready();
    int n;
    bit got;
    exp_t e;
    mode = 1;
    repeat (3) @(negedge clock);
    issue(1'b0, 2'd0, 8'h22, 8'h00);
    wait_resp(n, got);
    checks++; if (n != 7) begin failures++; $display("FAIL stale_latency got=%0d want=7", n); end
    checks++;
    if (!got) begin failures++; $display("FAIL stale_resp_timeout got=none want=resp"); end
    else begin
      e = sb.pop_front();
      if ({resp_error, resp_rdata} !== e) begin failures++; $display("FAIL stale_data got=%h want=%h", {resp_error, resp_rdata}, e); end
    end
    mode = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    exp_t e;
    mode = 2;
    issue(1'b0, 2'd0, 8'h33, 8'h00);
    void'(sb.pop_back());
    sb.push_back(exp_t'(9'h100));
    wait_resp(n, got);
    checks++; if (n != 17) begin failures++; $display("FAIL timeout_latency got=%0d want=17", n); end
    checks++;
    if (!got) begin failures++; $display("FAIL timeout_resp got=none want=resp"); end
    else begin
      e = sb.pop_front();
      if ({resp_error, resp_rdata} !== e) begin failures++; $display("FAIL timeout_data got=%h want=%h", {resp_error, resp_rdata}, e); end
    end
    @(negedge clock);
    checks++; if ({resp_valid, mem_select} !== 2'b00) begin failures++; $display("FAIL timeout_recover got=%b want=00", {resp_valid, mem_select}); end
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL timeout_idle_ready got=%b want=1", req_ready); end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    int got_n = 0;
    int extra = 0;
    exp_t e;
    min_gap = 99;
    fork
      begin
        req_valid = 1'b1;
        req_write = 1'b0;
        req_type = 2'd0;
        for (int i = 1; i <= 3; i++) begin
          int n = 0;
          while (!req_ready && n < 60) begin
            @(negedge clock);
            n++;
          end
          req_addr = 8'(i);
          @(posedge clock);
          if (req_ready) sb.push_back(exp_t'({1'b0, ref_mem[i]}));
          @(negedge clock);
        end
        req_valid = 1'b0;
      end
      begin
        int cyc = 0;
        while (got_n < 3 && cyc < 200) begin
          @(negedge clock);
          cyc++;
          if (resp_valid) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL b2b_unexpected got=%h want=none", {resp_error, resp_rdata}); end
            else begin
              e = sb.pop_front();
              if ({resp_error, resp_rdata} !== e) begin failures++; $display("FAIL b2b_data got=%h want=%h", {resp_error, resp_rdata}, e); end
            end
            got_n++;
          end
        end
      end
    join
    repeat (20) begin
      @(negedge clock);
      if (resp_valid) extra++;
    end
    checks++; if (got_n + extra != 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", got_n + extra); end
    checks++; if (min_gap < 2) begin failures++; $display("FAIL b2b_select_gap got=%0d want>=2", min_gap); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen = 0;
    bit got;
    exp_t e;
    issue(1'b0, 2'd0, 8'h44, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if ({mem_select, resp_valid, req_ready} !== 3'b001) begin failures++; $display("FAIL midreset_state got=%b want=001", {mem_select, resp_valid, req_ready}); end
    sb.delete();
    repeat (12) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_resp got=%0d want=0", seen); end
    issue(1'b0, 2'd2, 8'h45, 8'h00);
    wait_resp(n, got);
    checks++;
    if (!got) begin failures++; $display("FAIL midreset_after_timeout got=none want=resp"); end
    else begin
      e = sb.pop_front();
      if ({resp_error, resp_rdata} !== e || n != 7) begin failures++; $display("FAIL midreset_after got=%h/%0d want=%h/7", {resp_error, resp_rdata}, n, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_type = 2'd0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_read();
    test_write_read();
    test_stale_ready();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
